// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank: one write port, NRD combinational read ports,
// optional hardwired-zero entry 0, optional write bypass and a bulk-clear sequencer.
`timescale 1ns/1ps

module reg_bank_mp_rdport #(
  parameter int W       = 16,
  parameter int N       = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic [(1<<N)-1:0][W-1:0] mem_i,
  input  logic [N-1:0]             raddr_i,
  input  logic                     wr_acc_i,
  input  logic [N-1:0]             waddr_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o
);
  always_comb begin
    rdata_o = mem_i[raddr_i];
    if ((BYPASS != 0) && wr_acc_i && (waddr_i == raddr_i)) rdata_o = wdata_i;
    if ((ZERO_R0 != 0) && (raddr_i == '0))                 rdata_o = '0;
  end
endmodule

module reg_bank_mp #(
  parameter int W       = 16,
  parameter int N       = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [N-1:0]     addr_rd,
  input  logic [W-1:0]     data_in,
  input  logic [NRD*N-1:0] addr_rs,
  output logic [NRD*W-1:0] rs,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_drop
);
  localparam int DEPTH = 1 << N;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                    state_q, state_d;
  logic [N-1:0]              cnt_q, cnt_d;
  logic                      wr_drop_q, wr_drop_d;
  logic [DEPTH-1:0][W-1:0]   mem_q;
  logic                      wr_acc;

  // Writes to entry 0 vanish silently when it is hardwired; only FSM-busy rejects flag wr_drop.
  assign wr_acc    = we && !reset && (state_q == IDLE) &&
                     !((ZERO_R0 != 0) && (addr_rd == '0));
  assign wr_drop_d = we && (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {N{1'b1}}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = (state_q == DONE);
    wr_drop  = wr_drop_q;
  end

  // A write accepted alongside clr_req lands first; the sweep then overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 mem_q <= '0;
    else if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    else if (wr_acc)           mem_q[addr_rd] <= data_in;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_bank_mp_rdport #(.W(W), .N(N), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_rd (
      .mem_i    (mem_q),
      .raddr_i  (addr_rs[i*N +: N]),
      .wr_acc_i (wr_acc),
      .waddr_i  (addr_rd),
      .wdata_i  (data_in),
      .rdata_o  (rs[i*W +: W])
    );
  end
endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Multi-read-port register bank for the datapath register file.
- One write port, NRD asynchronous read ports, optional hardwired-zero register 0, and optional write-to-read bypass.
- A built-in bulk-clear sequencer zeroes the whole array on request, one entry per cycle, without a global reset.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
W, 16, register width in bits
N, 5, address width; depth = 2**N entries
NRD, 2, number of read ports (>=1)
ZERO_R0, 1, 1: entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, 1: an accepted write in the current cycle is forwarded combinationally to matching read ports

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
we  input  1  write enable
addr_rd  input  N  write address
data_in  input  W  write data
addr_rs  input  NRD*N  read addresses; port i at bits [i*N +: N]
rs  output  NRD*W  read data; port i at bits [i*W +: W]
clr_req  input  1  start bulk clear (sampled when sequencer idle)
clr_busy  output  1  high while clear sequence runs
clr_done  output  1  one-cycle pulse when clear completes
wr_drop  output  1  one-cycle pulse: a write was rejected in the previous cycle

Behaviour:
Reset (async assert, release synchronous to clk):
- All 2**N entries = 0; FSM = IDLE; clear counter = 0.
- clr_busy = 0, clr_done = 0, wr_drop = 0.
- rs = 0 on all ports.
- Reset asserted mid-clear aborts the sequence immediately.

Write (IDLE state only):
- Write accepted iff we=1, FSM=IDLE, and NOT (ZERO_R0=1 and addr_rd=0).
- Accepted write updates entry addr_rd with data_in at the clock edge.
- A write with ZERO_R0=1 and addr_rd=0 is silently discarded; wr_drop is not asserted.

Read (combinational):
- rs[i] = entry[addr_rs[i]].
- With ZERO_R0=1 and addr_rs[i]=0, rs[i] = 0 regardless of stored value.
- BYPASS=1: if the write is accepted this cycle and addr_rd == addr_rs[i], then rs[i] = data_in (same cycle).
- BYPASS=0: the new value is visible the cycle after the write edge.
- Multiple read ports may address the same entry; each returns the same value.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE -> CLEAR when clr_req=1. The counter loads 0; clr_busy rises the next cycle.
- CLEAR: each cycle, entry[counter] <= 0 and counter increments.
- CLEAR -> DONE after entry 2**N-1 is written. CLEAR lasts exactly 2**N cycles.
- DONE: clr_done=1 for one cycle, clr_busy=0, then -> IDLE.
- clr_busy = 1 exactly in CLEAR.
- clr_req is ignored in CLEAR and DONE; no queuing.
- Any we=1 while FSM != IDLE is rejected. wr_drop pulses the following cycle, once per rejected cycle.
- Reads during CLEAR return current contents (partially cleared). The bypass is inactive because no write is accepted.
- clr_req and we in the same IDLE cycle: the write is accepted, and the clear begins on the next edge, so it overwrites the written entry.

Width rules:
- Counter is N bits.
- The terminal condition uses counter == 2**N-1, not counter overflow.

Test Plan:
1. Reset, then read all addresses on both ports -> every rs = 0x0000; clr_busy=0, clr_done=0, wr_drop=0.
2. Write 0xBEEF to addr 5, BYPASS=1, addr_rs0=5 in the same cycle -> rs0=0xBEEF combinationally that cycle; rs1 (addr 5) = 0xBEEF on the next cycle.
3. ZERO_R0=1: write 0x1234 to addr 0 -> rs0(addr 0)=0x0000 afterwards; wr_drop stays 0.
4. Fill all 32 entries with value = addr+1, pulse clr_req -> clr_busy high for exactly 32 cycles; clr_done pulses one cycle later; all entries read 0.
5. During CLEAR, write 0xAAAA to addr 31 -> write rejected; wr_drop pulses the next cycle; addr 31 reads 0 after DONE.
6. Assert reset at clear counter=10 -> clr_busy=0 immediately and all entries read 0. After release, a write to addr 3 of 0x0055 is accepted and reads back 0x0055.
